sha1_pad_sched: RTL and testbench
=================================

// Module: sha1_pad_sched
// PURPOSE
//  Sequencer between the 32-bit word FIFO and sha_1_core. Buffers one 512-bit block,
//  appends SHA-1 padding and the 64-bit bit-length, and issues 16-word bursts to the core.
//  Drives use_pre_cv/sha_1_end per block and reports the final digest.
//  Turns the single-block path into arbitrary-length hashing.
// PARAMETERS
//  LEN_W     64  width of internal message bit-length counter (<=64; zero-extended into words 14/15)
//  BUSY_TO   255 max cycles to wait for core_busy to rise after a burst before flagging err
// PORTS
//  clk           in   1    clock
//  rst           in   1    asynchronous active-high reset
//  in_data       in   32   message word, big-endian bytes ([31:24] first)
//  in_vld        in   1    in_data valid
//  in_last       in   1    final word of message (qualified by in_vld)
//  in_nbytes     in   3    valid bytes in final word, 0..4 (0 only for empty message)
//  in_rdy        out  1    word accepted when in_vld & in_rdy
//  core_din      out  32   word to sha_1_core din
//  core_din_vld  out  1    to sha_1_core din_vld
//  core_use_pre_cv out 1   0 on first block of message, 1 after
//  core_sha_1_end out 1    1 on final block of message
//  core_busy     in   1    from sha_1_core busy
//  core_dout     in   160  from sha_1_core dout
//  core_dout_vld in   1    from sha_1_core dout_vld
//  digest        out  160  registered digest of last completed message
//  digest_vld    out  1    1-cycle pulse when digest updated
//  err           out  1    sticky; BUSY_TO expired; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0, in_rdy 0 for the reset cycle, then 1 in FILL; buffer/counters 0.
//  FSM: FILL -> (16 words | in_last) -> PAD -> LEN -> ISSUE -> WAIT -> FILL/DONE/PAD2.
//  FILL: in_rdy=1; word written at wptr, wptr++, bitlen += 32 (in_nbytes*8 on last word).
//   wptr==16 without last -> ISSUE (sha_1_end=0). in_rdy=0 outside FILL.
//  PAD: last word with nbytes<4: byte nbytes set to 0x80, lower bytes zeroed (partial word).
//   nbytes==4 or 0: 0x80000000 written at next wptr. Remaining words up to 13 zeroed.
//   If 0x80 lands at word index >=14 -> zero to 15, issue block (end=0), then PAD2:
//   fresh all-zero block with 0x80 suppressed, then LEN.
//  LEN: word14=bitlen[63:32], word15=bitlen[31:0]; sha_1_end=1.
//  ISSUE: 16 consecutive cycles core_din_vld=1, words 0..15; use_pre_cv/sha_1_end held
//   stable for all 16 cycles. Issue starts only when core_busy==0.
//  WAIT: wait for core_busy 1 then 0 (timeout BUSY_TO on the rise -> err=1, go FILL).
//   Non-final -> FILL, use_pre_cv=1 from now. Final -> DONE.
//  DONE: on core_dout_vld latch core_dout into digest, pulse digest_vld next cycle,
//   clear bitlen/use_pre_cv, go FILL. Block buffer reused; no overlap between messages.
//  Latency "abc": last word accepted -> first core_din_vld <= 3 cycles.
//  in_vld during non-FILL: ignored (in_rdy=0). in_nbytes>4 treated as 4.
//  bitlen wraps mod 2^LEN_W silently. rst mid-ISSUE: din_vld drops immediately; core reset
//   by its own reset and not re-synchronised here.
// STRUCTURE
//  Package sha1_pkg: state enum; PAD_WORD=32'h8000_0000; BLK_WORDS=16; LEN_WORD_HI=14.
//  Package sha1_pkg: IV constants for bench use.
//  One sub-module: sha1_blk_buf (16x32 regfile, 1 write port, 1 read port, clear-range op).
//  FSM, counters and pad logic stay in this module.
// TESTING
//  "abc" (0x61626300,last,nbytes=3) -> one burst: w0=0x61626380, w1..14=0, w15=0x18.
//   digest=a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
//  Empty message (in_last, nbytes=0) -> w0=0x80000000, w15=0.
//   digest=da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
//  56-byte message -> two bursts; second all-zero except w15=0x1C0.
//   use_pre_cv 0 then 1; sha_1_end 0 then 1.
//  64-byte message, in_vld toggled randomly -> exactly 16 accepts then in_rdy=0.
//   2 bursts; digest matches model.
//  core_busy held 0 after burst -> err=1 after BUSY_TO cycles, FSM back in FILL.
//  rst asserted on ISSUE word 7 -> core_din_vld=0 same cycle.
//   Next "abc" still yields the a9993e36... digest.

Source files
------------

// File: rtl/sha1_pad_sched_pkg.sv
// rtl/sha1_pad_sched_pkg.sv - shared types and constants for the SHA-1 padding sequencer
package sha1_pkg;

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_PAD   = 3'd1,
        S_PAD2  = 3'd2,
        S_LEN   = 3'd3,
        S_ISSUE = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
    localparam int          BLK_WORDS   = 16;
    localparam int          LEN_WORD_HI = 14;

    // Initial chaining value, used by the bench to model the core.
    localparam logic [159:0] SHA1_IV =
        160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    // Keep the top nb message bytes, place the 0x80 marker right after them.
    function automatic logic [31:0] pad_last_word(input logic [31:0] d, input logic [2:0] nb);
        logic [31:0] keep_mask;
        keep_mask = ~(32'hFFFF_FFFF >> {nb, 3'b000});
        return (d & keep_mask) | (PAD_WORD >> {nb, 3'b000});
    endfunction

endpackage

// File: rtl/sha1_pad_sched_if.sv
// rtl/sha1_pad_sched_if.sv - message word stream from the word FIFO into the sequencer
interface sha1_pad_sched_if;
    logic [31:0] in_data;
    logic        in_vld;
    logic        in_last;
    logic [2:0]  in_nbytes;
    logic        in_rdy;

    modport master (output in_data, output in_vld, output in_last, output in_nbytes, input in_rdy);
    modport slave  (input in_data, input in_vld, input in_last, input in_nbytes, output in_rdy);
endinterface

// File: rtl/sha1_blk_buf.sv
// rtl/sha1_blk_buf.sv - 16x32 block buffer with one write port, one read port and range clear
module sha1_blk_buf
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        clr_en,
    input  logic [3:0]  clr_lo,
    input  logic [3:0]  clr_hi,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] mem [BLK_WORDS];

    // Word update: an explicit write wins over a range clear on the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BLK_WORDS; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < BLK_WORDS; i++) begin
                if (we && waddr == 4'(i))
                    mem[i] <= wdata;
                else if (clr_en && 4'(i) >= clr_lo && 4'(i) <= clr_hi)
                    mem[i] <= '0;
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sha1_pad_sched.sv
// rtl/sha1_pad_sched.sv - buffers message blocks, applies SHA-1 padding and feeds sha_1_core
module sha1_pad_sched
    import sha1_pkg::*;
#(
    parameter int LEN_W   = 64,
    parameter int BUSY_TO = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    sha1_pad_sched_if.slave       in_if,
    output logic [31:0]           core_din,
    output logic                  core_din_vld,
    output logic                  core_use_pre_cv,
    output logic                  core_sha_1_end,
    input  logic                  core_busy,
    input  logic [159:0]          core_dout,
    input  logic                  core_dout_vld,
    output logic [159:0]          digest,
    output logic                  digest_vld,
    output logic                  err
);

    localparam int TO_W = $clog2(BUSY_TO + 1);

    state_t             state;
    logic [4:0]         wptr;
    logic [3:0]         rptr;
    logic [LEN_W-1:0]   bitlen;
    logic               partial;
    logic               pad_carry;
    logic               need_pad2;
    logic               seen_busy;
    logic [TO_W-1:0]    to_cnt;

    logic [2:0]         nb;
    logic               accept;
    logic [4:0]         p80;
    logic [5:0]         add_bits;
    logic [63:0]        len64;

    logic               buf_we;
    logic [3:0]         buf_waddr;
    logic [31:0]        buf_wdata;
    logic               buf_clr_en;
    logic [3:0]         buf_clr_lo;
    logic [4:0]         clr_lo5;
    logic [31:0]        buf_rdata;
    logic [31:0]        issue_word;

    assign nb       = (in_if.in_nbytes > 3'd4) ? 3'd4 : in_if.in_nbytes;
    assign accept   = (state == S_FILL) && in_if.in_rdy && in_if.in_vld;
    assign p80      = partial ? (wptr - 5'd1) : wptr;
    assign add_bits = in_if.in_last ? {nb, 3'b000} : 6'd32;
    assign len64    = 64'(bitlen);

    // Buffer write/clear control: data words in FILL, marker and tail zeroing in PAD/PAD2.
    always_comb begin
        buf_we     = 1'b0;
        buf_waddr  = wptr[3:0];
        buf_wdata  = in_if.in_data;
        buf_clr_en = 1'b0;
        buf_clr_lo = 4'd0;
        clr_lo5    = 5'd0;
        case (state)
            S_FILL: begin
                if (accept && !(in_if.in_last && nb == 3'd0)) begin
                    buf_we = 1'b1;
                    if (in_if.in_last && nb != 3'd4)
                        buf_wdata = pad_last_word(in_if.in_data, nb);
                end
            end
            S_PAD: begin
                if (!partial && !wptr[4]) begin
                    buf_we    = 1'b1;
                    buf_wdata = PAD_WORD;
                end
                clr_lo5 = partial ? wptr : (wptr + 5'd1);
                if (!clr_lo5[4]) begin
                    buf_clr_en = 1'b1;
                    buf_clr_lo = clr_lo5[3:0];
                end
            end
            S_PAD2: begin
                buf_clr_en = 1'b1;
                buf_we     = pad_carry;
                buf_waddr  = 4'd0;
                buf_wdata  = PAD_WORD;
            end
            default: ;
        endcase
    end

    sha1_blk_buf u_buf (
        .clk    (clk),
        .rst    (rst),
        .we     (buf_we),
        .waddr  (buf_waddr),
        .wdata  (buf_wdata),
        .clr_en (buf_clr_en),
        .clr_lo (buf_clr_lo),
        .clr_hi (4'd15),
        .raddr  (rptr),
        .rdata  (buf_rdata)
    );

    // Length words are muxed in at issue time so LEN needs no extra write cycles.
    always_comb begin
        issue_word = buf_rdata;
        if (core_sha_1_end && rptr == 4'(LEN_WORD_HI))
            issue_word = len64[63:32];
        else if (core_sha_1_end && rptr == 4'(LEN_WORD_HI + 1))
            issue_word = len64[31:0];
    end

    // Sequencer FSM with registered handshake and core-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_FILL;
            wptr            <= '0;
            rptr            <= '0;
            bitlen          <= '0;
            partial         <= 1'b0;
            pad_carry       <= 1'b0;
            need_pad2       <= 1'b0;
            seen_busy       <= 1'b0;
            to_cnt          <= '0;
            in_if.in_rdy    <= 1'b0;
            core_din        <= '0;
            core_din_vld    <= 1'b0;
            core_use_pre_cv <= 1'b0;
            core_sha_1_end  <= 1'b0;
            digest          <= '0;
            digest_vld      <= 1'b0;
            err             <= 1'b0;
        end else begin
            core_din_vld <= 1'b0;
            digest_vld   <= 1'b0;
            case (state)
                S_FILL: begin
                    in_if.in_rdy <= 1'b1;
                    if (accept) begin
                        bitlen <= bitlen + LEN_W'(add_bits);
                        if (in_if.in_last) begin
                            if (nb != 3'd0) wptr <= wptr + 5'd1;
                            partial      <= (nb != 3'd0) && (nb != 3'd4);
                            in_if.in_rdy <= 1'b0;
                            state        <= S_PAD;
                        end else begin
                            wptr <= wptr + 5'd1;
                            if (wptr == 5'd15) begin
                                in_if.in_rdy   <= 1'b0;
                                core_sha_1_end <= 1'b0;
                                rptr           <= '0;
                                state          <= S_ISSUE;
                            end
                        end
                    end
                end
                S_PAD: begin
                    // No room left for the length words: ship this block and pad a fresh one.
                    if (p80 >= 5'd14) begin
                        pad_carry      <= (p80 == 5'd16);
                        need_pad2      <= 1'b1;
                        core_sha_1_end <= 1'b0;
                        rptr           <= '0;
                        state          <= S_ISSUE;
                    end else begin
                        state <= S_LEN;
                    end
                end
                S_PAD2: begin
                    need_pad2 <= 1'b0;
                    pad_carry <= 1'b0;
                    state     <= S_LEN;
                end
                S_LEN: begin
                    core_sha_1_end <= 1'b1;
                    rptr           <= '0;
                    state          <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (rptr != 4'd0 || !core_busy) begin
                        core_din     <= issue_word;
                        core_din_vld <= 1'b1;
                        rptr         <= rptr + 4'd1;
                        if (rptr == 4'd15) begin
                            seen_busy <= 1'b0;
                            to_cnt    <= '0;
                            state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!seen_busy) begin
                        if (core_busy) begin
                            seen_busy <= 1'b1;
                        end else if (to_cnt == TO_W'(BUSY_TO)) begin
                            // Core never started: abandon the message and accept a new one.
                            err             <= 1'b1;
                            wptr            <= '0;
                            bitlen          <= '0;
                            need_pad2       <= 1'b0;
                            pad_carry       <= 1'b0;
                            core_use_pre_cv <= 1'b0;
                            core_sha_1_end  <= 1'b0;
                            in_if.in_rdy    <= 1'b1;
                            state           <= S_FILL;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end else if (core_sha_1_end && core_dout_vld) begin
                        digest          <= core_dout;
                        digest_vld      <= 1'b1;
                        bitlen          <= '0;
                        wptr            <= '0;
                        core_use_pre_cv <= 1'b0;
                        core_sha_1_end  <= 1'b0;
                        in_if.in_rdy    <= 1'b1;
                        state           <= S_FILL;
                    end else if (!core_busy) begin
                        if (core_sha_1_end) begin
                            state <= S_DONE;
                        end else begin
                            core_use_pre_cv <= 1'b1;
                            if (need_pad2) begin
                                state <= S_PAD2;
                            end else begin
                                wptr         <= '0;
                                in_if.in_rdy <= 1'b1;
                                state        <= S_FILL;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (core_dout_vld) begin
                        digest          <= core_dout;
                        digest_vld      <= 1'b1;
                        bitlen          <= '0;
                        wptr            <= '0;
                        core_use_pre_cv <= 1'b0;
                        core_sha_1_end  <= 1'b0;
                        in_if.in_rdy    <= 1'b1;
                        state           <= S_FILL;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_pad_sched.sv
// tb/tb_sha1_pad_sched.sv - scoreboard bench for the SHA-1 padding sequencer
module tb_sha1_pad_sched;
    import sha1_pkg::*;

    localparam int TB_BUSY_TO = 20;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] word_q_t [$];
    typedef struct {
        logic [31:0] w;
        logic        pre;
        logic        fin;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         core_busy = 1'b0;
    logic [159:0] core_dout = '0;
    logic         core_dout_vld = 1'b0;
    logic [31:0]  core_din;
    logic         core_din_vld;
    logic         core_use_pre_cv;
    logic         core_sha_1_end;
    logic [159:0] digest;
    logic         digest_vld;
    logic         err;

    sha1_pad_sched_if bus ();

    sha1_pad_sched #(.LEN_W(64), .BUSY_TO(TB_BUSY_TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_if           (bus.slave),
        .core_din        (core_din),
        .core_din_vld    (core_din_vld),
        .core_use_pre_cv (core_use_pre_cv),
        .core_sha_1_end  (core_sha_1_end),
        .core_busy       (core_busy),
        .core_dout       (core_dout),
        .core_dout_vld   (core_dout_vld),
        .digest          (digest),
        .digest_vld      (digest_vld),
        .err             (err)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q [$];
    logic [159:0] dig_q [$];
    bit   sb_off    = 1'b0;
    bit   core_dead = 1'b0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] sha1_comp(input logic [159:0] hin, input blk_t b);
        logic [31:0] w [80];
        logic [31:0] a, bb, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = b[i];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        {a, bb, c, d, e} = hin;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (bb & c) | (~bb & d);          k = 32'h5a827999; end
            else if (i < 40) begin f = bb ^ c ^ d;                    k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = bb ^ c ^ d;                    k = 32'hca62c1d6; end
            t  = {a[26:0], a[31:27]} + f + e + k + w[i];
            e  = d;
            d  = c;
            c  = {bb[1:0], bb[31:2]};
            bb = a;
            a  = t;
        end
        return {hin[159:128] + a, hin[127:96] + bb, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    task automatic push_burst(input blk_t b, input logic pre, input logic fin);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.w = b[i]; e.pre = pre; e.fin = fin;
            exp_q.push_back(e);
        end
    endtask

    // Behavioural sha_1_core: gathers bursts, computes the compression, drives busy/dout.
    initial begin
        blk_t         cblk;
        int           cnt = 0;
        int           busy_left = 0;
        bit           dout_pend = 0;
        logic         cur_pre = 0, cur_fin = 0;
        logic [159:0] h = SHA1_IV;
        forever begin
            @(negedge clk);
            core_dout_vld = 1'b0;
            if (rst) begin
                cnt = 0; busy_left = 0; dout_pend = 0; core_busy = 1'b0;
            end else begin
                if (dout_pend) begin
                    core_dout_vld = 1'b1;
                    dout_pend = 0;
                end
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) begin
                        core_busy = 1'b0;
                        dout_pend = cur_fin;
                    end
                end
                if (core_din_vld) begin
                    if (cnt == 0) begin
                        cur_pre = core_use_pre_cv;
                        cur_fin = core_sha_1_end;
                    end
                    cblk[cnt] = core_din;
                    cnt++;
                    if (cnt == 16) begin
                        cnt = 0;
                        h = sha1_comp(cur_pre ? h : SHA1_IV, cblk);
                        core_dout = h;
                        if (!core_dead) begin
                            core_busy = 1'b1;
                            busy_left = 6;
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a burst word or a digest.
    initial begin
        exp_t e;
        logic [159:0] d;
        forever begin
            @(negedge clk);
            if (!sb_off && core_din_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 160'(core_din), 160'h0 - 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("burst_word", 160'(core_din), 160'(e.w));
                    chk("burst_flags", 160'({core_use_pre_cv, core_sha_1_end}), 160'({e.pre, e.fin}));
                end
            end
            if (digest_vld) begin
                if (dig_q.size() == 0) begin
                    chk("unexpected_digest", digest, 160'h0 - 1);
                end else begin
                    d = dig_q.pop_front();
                    chk("digest", digest, d);
                end
            end
        end
    end

    task automatic send_msg(input word_q_t w, input logic [2:0] nb_last, input bit rnd);
        int i = 0;
        int guard = 0;
        while (i < w.size() && guard < 3000) begin
            @(negedge clk);
            guard++;
            bus.in_data   = w[i];
            bus.in_last   = (i == w.size() - 1);
            bus.in_nbytes = bus.in_last ? nb_last : 3'd4;
            bus.in_vld    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.in_vld && bus.in_rdy) i++;
        end
        if (guard >= 3000) chk("send_timeout", 160'(i), 160'(w.size()));
        @(posedge clk);
        #1;
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_digest(input string name);
        int n = 0;
        while (!digest_vld && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!digest_vld) chk(name, 160'(0), 160'(1));
        @(negedge clk);
    endtask

    initial begin
        blk_t    b0, b1;
        word_q_t msg;
        int      n, last_vld, rdy_hits;
        logic [159:0] dig64;

        bus.in_data = '0; bus.in_vld = 1'b0; bus.in_last = 1'b0; bus.in_nbytes = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_rdy", 160'(bus.in_rdy), 160'(0));
        chk("rst_outputs", 160'({core_din_vld, core_use_pre_cv, core_sha_1_end, digest_vld, err}), 160'(0));
        chk("rst_digest", digest, 160'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("fill_in_rdy", 160'(bus.in_rdy), 160'(1));

        // "abc": single burst, latency from last accept to first word
        for (int i = 0; i < 16; i++) b0[i] = 32'h0;
        b0[0] = 32'h61626380; b0[15] = 32'h18;
        push_burst(b0, 1'b0, 1'b1);
        dig_q.push_back(160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        msg = '{32'h61626300};
        send_msg(msg, 3'd3, 1'b0);
        n = 0;
        while (n < 10) begin
            @(posedge clk); #1;
            n++;
            if (core_din_vld) break;
        end
        chk("abc_latency", 160'(n <= 3 && core_din_vld), 160'(1));
        wait_digest("abc_digest_timeout");

        // Empty message
        for (int i = 0; i < 16; i++) b0[i] = 32'h0;
        b0[0] = PAD_WORD;
        push_burst(b0, 1'b0, 1'b1);
        dig_q.push_back(160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709);
        msg = '{32'h0};
        send_msg(msg, 3'd0, 1'b0);
        wait_digest("empty_digest_timeout");

        // 56-byte message: marker lands on word 14, length spills into a second block
        msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
        for (int i = 0; i < 16; i++) b0[i] = (i < 14) ? msg[i] : 32'h0;
        b0[14] = PAD_WORD;
        for (int i = 0; i < 16; i++) b1[i] = 32'h0;
        b1[15] = 32'h1C0;
        push_burst(b0, 1'b0, 1'b0);
        push_burst(b1, 1'b1, 1'b1);
        dig_q.push_back(160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);
        send_msg(msg, 3'd4, 1'b0);
        wait_digest("m56_digest_timeout");

        // 64-byte message with random in_vld gaps
        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(32'h01020304 * (i + 1) ^ 32'hA5A5_0000);
        for (int i = 0; i < 16; i++) b0[i] = msg[i];
        for (int i = 0; i < 16; i++) b1[i] = 32'h0;
        b1[0] = PAD_WORD; b1[15] = 32'h200;
        dig64 = sha1_comp(sha1_comp(SHA1_IV, b0), b1);
        push_burst(b0, 1'b0, 1'b0);
        push_burst(b1, 1'b1, 1'b1);
        dig_q.push_back(dig64);
        send_msg(msg, 3'd4, 1'b1);
        rdy_hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_vld  = 1'b1;
            bus.in_data = 32'hDEAD_BEEF;
            if (bus.in_rdy) rdy_hits++;
        end
        bus.in_vld = 1'b0;
        chk("m64_no_extra_accept", 160'(rdy_hits), 160'(0));
        wait_digest("m64_digest_timeout");

        // Core never goes busy: timeout sets err and returns to FILL
        core_dead = 1'b1;
        for (int i = 0; i < 16; i++) b0[i] = 32'h0;
        b0[0] = 32'h61626380; b0[15] = 32'h18;
        push_burst(b0, 1'b0, 1'b1);
        msg = '{32'h61626300};
        send_msg(msg, 3'd3, 1'b0);
        n = 0; last_vld = 0;
        while (!err && n < 300) begin
            @(negedge clk);
            n++;
            if (core_din_vld) last_vld = n;
        end
        chk("timeout_err", 160'(err), 160'(1));
        chk("timeout_delay", 160'((n - last_vld) >= TB_BUSY_TO && (n - last_vld) <= TB_BUSY_TO + 2), 160'(1));
        chk("timeout_fill", 160'(bus.in_rdy), 160'(1));
        chk("timeout_sb_empty", 160'(exp_q.size()), 160'(0));
        core_dead = 1'b0;

        // Reset in the middle of a burst
        sb_off = 1'b1;
        msg = '{32'h61626300};
        send_msg(msg, 3'd3, 1'b0);
        n = 0;
        for (int i = 0; i < 50 && n < 8; i++) begin
            @(negedge clk);
            if (core_din_vld) n++;
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_issue_vld", 160'(core_din_vld), 160'(0));
        chk("rst_clears_err", 160'(err), 160'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb_off = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_rdy", 160'(bus.in_rdy), 160'(1));

        for (int i = 0; i < 16; i++) b0[i] = 32'h0;
        b0[0] = 32'h61626380; b0[15] = 32'h18;
        push_burst(b0, 1'b0, 1'b1);
        dig_q.push_back(160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        send_msg(msg, 3'd3, 1'b0);
        wait_digest("abc2_digest_timeout");

        repeat (4) @(negedge clk);
        chk("sb_words_drained", 160'(exp_q.size()), 160'(0));
        chk("sb_digests_drained", 160'(dig_q.size()), 160'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
